// File: rtl/bus_mult_pkg.sv
// bus_mult_pkg: shared FSM state type and legal WIDTH bounds for bus_mult_seq.
package bus_mult_pkg;
   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 32;
   typedef enum logic [2:0] {IDLE, LOAD2, CALC, OUT_LSB, OUT_MSB} state_t;
endpackage

// File: rtl/mult_shift_add_core.sv
// mult_shift_add_core: radix-2 shift-add datapath; one partial product per run cycle.
module mult_shift_add_core #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 run,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   sum,
   output logic                 last
);
   localparam int CW = $clog2(WIDTH);
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   // sum is the accumulator after this cycle's step, so the final product is visible on the last run cycle
   assign sum  = acc + (mplier[0] ? mcand : '0);
   assign last = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (run) begin
         acc    <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/bus_mult_seq.sv
// bus_mult_seq: two-beat operand load, WIDTH-cycle shift-add, two-beat result drive on a shared bus.
// Define BUS_MULT_SIGNED_EN for two's-complement operands and result.
module bus_mult_seq
   import bus_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_oe,
   output logic             lsb_out,
   output logic             msb_out,
   output logic             done,
   output logic             busy
);
   state_t             state;
   logic [WIDTH-1:0]   opnd1, hi, mag1, mag2;
   logic [2*WIDTH-1:0] sum, prod;
   logic               last;
`ifdef BUS_MULT_SIGNED_EN
   logic neg;
   assign mag1 = opnd1[WIDTH-1] ? -opnd1 : opnd1;
   assign mag2 = data_in[WIDTH-1] ? -data_in : data_in;
   assign prod = neg ? -sum : sum;
   always_ff @(posedge clk) begin
      if (rst) neg <= 1'b0;
      else if (state == LOAD2) neg <= opnd1[WIDTH-1] ^ data_in[WIDTH-1];
   end
`else
   assign mag1 = opnd1;
   assign mag2 = data_in;
   assign prod = sum;
`endif
   mult_shift_add_core #(.WIDTH(WIDTH)) core (
      .clk  (clk),
      .rst  (rst),
      .load (state == LOAD2),
      .run  (state == CALC),
      .a    (mag1),
      .b    (mag2),
      .sum  (sum),
      .last (last)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         opnd1    <= '0;
         hi       <= '0;
         data_out <= '0;
         data_oe  <= 1'b0;
         lsb_out  <= 1'b0;
         msb_out  <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         data_out <= '0;
         data_oe  <= 1'b0;
         lsb_out  <= 1'b0;
         msb_out  <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: if (start) begin
               opnd1 <= data_in;
               busy  <= 1'b1;
               state <= LOAD2;
            end
            LOAD2: state <= CALC;
            CALC: if (last) begin
               data_out <= prod[WIDTH-1:0];
               hi       <= prod[2*WIDTH-1:WIDTH];
               data_oe  <= 1'b1;
               lsb_out  <= 1'b1;
               state    <= OUT_LSB;
            end
            OUT_LSB: begin
               data_out <= hi;
               data_oe  <= 1'b1;
               msb_out  <= 1'b1;
               done     <= 1'b1;
               state    <= OUT_MSB;
            end
            OUT_MSB: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_mult_seq.sv
// tb_bus_mult_seq: directed vector table plus overlap/reset sequences on WIDTH=8 and WIDTH=16 instances.
module tb_bus_mult_seq;
   logic        clk = 1'b0, rst = 1'b1, go = 1'b0, sel = 1'b0;
   logic [15:0] din = '0;
   logic [7:0]  d8_out;
   logic [15:0] d16_out, o_data;
   logic        oe8, lsb8, msb8, done8, busy8;
   logic        oe16, lsb16, msb16, done16, busy16;
   logic        o_oe, o_lsb, o_msb, o_done, o_busy;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   bus_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(go & ~sel), .data_in(din[7:0]),
      .data_out(d8_out), .data_oe(oe8), .lsb_out(lsb8), .msb_out(msb8), .done(done8), .busy(busy8)
   );
   bus_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(go & sel), .data_in(din),
      .data_out(d16_out), .data_oe(oe16), .lsb_out(lsb16), .msb_out(msb16), .done(done16), .busy(busy16)
   );

   assign o_data = sel ? d16_out : {8'h00, d8_out};
   assign o_oe   = sel ? oe16 : oe8;
   assign o_lsb  = sel ? lsb16 : lsb8;
   assign o_msb  = sel ? msb16 : msb8;
   assign o_done = sel ? done16 : done8;
   assign o_busy = sel ? busy16 : busy8;

   typedef struct {
      string      name;
      logic [7:0] a, b, lo, hi;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // start in cycle 0, second operand in cycle 1; extra start pulses at cycles xs1/xs2 must be ignored
   task automatic run_op(input string name, input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] lo, input logic [15:0] hi, input int xs1, input int xs2);
      int w;
      int bad;
      w   = wide ? 16 : 8;
      bad = 0;
      @(posedge clk); #1;
      sel = wide;
      #1;
      chk({name, " idle_before"}, o_busy, 0);
      go  = 1'b1;
      din = a;
      @(posedge clk); #1;
      go  = 1'b0;
      din = b;
      chk({name, " busy_load2"}, o_busy, 1);
      for (int c = 2; c <= w + 3; c++) begin
         @(posedge clk); #1;
         if (c == w + 2) begin
            chk({name, " lsb_flags"}, {o_oe, o_lsb, o_msb, o_done}, 4'b1100);
            chk({name, " lsb_data"}, o_data, lo);
         end else if (c == w + 3) begin
            chk({name, " msb_flags"}, {o_oe, o_lsb, o_msb, o_done}, 4'b1011);
            chk({name, " msb_data"}, o_data, hi);
         end else if (o_oe | o_lsb | o_msb | o_done | (o_data != 16'h0) | !o_busy) begin
            bad++;
         end
         go  = (c == xs1) || (c == xs2);
         din = 16'h5A5A;
      end
      chk({name, " quiet_phase"}, bad, 0);
   endtask

   initial begin
      int quiet;
`ifdef BUS_MULT_SIGNED_EN
      vecs[0] = '{"s5x3",     8'h05, 8'h03, 8'h0F, 8'h00};
      vecs[1] = '{"sm1xm1",   8'hFF, 8'hFF, 8'h01, 8'h00};
      vecs[2] = '{"sm1x2",    8'hFF, 8'h02, 8'hFE, 8'hFF};
      vecs[3] = '{"s80x80",   8'h80, 8'h80, 8'h00, 8'h40};
      vecs[4] = '{"szero",    8'h00, 8'h55, 8'h00, 8'h00};
      vecs[5] = '{"s7Fx81",   8'h7F, 8'h81, 8'hFF, 8'hC0};
      vecs[6] = '{"sm3x4",    8'hFD, 8'h04, 8'hF4, 8'hFF};
`else
      vecs[0] = '{"u5x3",     8'h05, 8'h03, 8'h0F, 8'h00};
      vecs[1] = '{"uFFxFF",   8'hFF, 8'hFF, 8'h01, 8'hFE};
      vecs[2] = '{"uzero",    8'h00, 8'h55, 8'h00, 8'h00};
      vecs[3] = '{"u80x02",   8'h80, 8'h02, 8'h00, 8'h01};
      vecs[4] = '{"u0Cx0D",   8'h0C, 8'h0D, 8'h9C, 8'h00};
      vecs[5] = '{"uABxCD",   8'hAB, 8'hCD, 8'hEF, 8'h88};
      vecs[6] = '{"u7Fx81",   8'h7F, 8'h81, 8'hFF, 8'h3F};
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_w8", {d8_out, oe8, lsb8, msb8, done8, busy8}, 13'h0);
      chk("reset_w16", {d16_out, oe16, lsb16, msb16, done16, busy16}, 21'h0);
      for (int i = 0; i < 7; i++)
         run_op(vecs[i].name, 1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b},
                {8'h00, vecs[i].lo}, {8'h00, vecs[i].hi}, -1, -1);
      run_op("overlap7x9", 1'b0, 16'h0007, 16'h0009, 16'h003F, 16'h0000, 4, 11);
      run_op("start_c12", 1'b0, 16'h0002, 16'h0003, 16'h0006, 16'h0000, -1, -1);
`ifdef BUS_MULT_SIGNED_EN
      run_op("w16_m1x2", 1'b1, 16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, -1, -1);
`else
      run_op("w16_FFFFx2", 1'b1, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001, -1, -1);
`endif
      // abort in the sixth CALC cycle (cycle 7 after start)
      @(posedge clk); #1;
      sel = 1'b0;
      go  = 1'b1;
      din = 16'h0012;
      @(posedge clk); #1;
      go  = 1'b0;
      din = 16'h0034;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_outputs", {d8_out, oe8, lsb8, msb8, done8}, 12'h0);
      chk("abort_busy", busy8, 0);
      quiet = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (oe8 | lsb8 | msb8 | done8 | busy8) quiet++;
      end
      chk("abort_no_output_phase", quiet, 0);
      rst = 1'b1;
      go  = 1'b1;
      din = 16'h0003;
      @(posedge clk); #1;
      rst = 1'b0;
      go  = 1'b0;
      chk("rst_over_start", busy8, 0);
      run_op("post_rst_2x2", 1'b0, 16'h0002, 16'h0002, 16'h0004, 16'h0000, -1, -1);
      @(posedge clk); #1;
      chk("final_idle", busy8, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bus_mult_seq.md
BUS_MULT_SEQ -- requirements
Module: bus_mult_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width; legal values are 4..32.
REQ-002 Port clk, input, 1, SHALL be the single clock; all logic is posedge clk.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port start, input, 1, SHALL be a one-cycle request; it also qualifies operand 1 on data_in.
REQ-005 Port data_in, input, WIDTH, SHALL be the operand bus sampled by the block.
REQ-006 Port data_out, output, WIDTH, SHALL carry result halves; it is 0 when data_oe=0.
REQ-007 Port data_oe, output, 1, SHALL mark cycles in which the block drives the shared bus.
REQ-008 Port lsb_out, output, 1, SHALL be high in the cycle data_out holds product[WIDTH-1:0].
REQ-009 Port msb_out, output, 1, SHALL be high in the cycle data_out holds product[2*WIDTH-1:WIDTH].
REQ-010 Port done, output, 1, SHALL be a one-cycle pulse coincident with msb_out.
REQ-011 Port busy, output, 1, SHALL be high in every state except IDLE.

Function
REQ-012 States SHALL be: IDLE, LOAD2, CALC, OUT_LSB, OUT_MSB.
REQ-013 IDLE with start=1 SHALL capture data_in as opnd1 and move to LOAD2.
REQ-014 LOAD2 SHALL capture data_in as opnd2, clear the accumulator and the counter, and move to CALC.
REQ-015 CALC SHALL run radix-2 shift-add for exactly WIDTH cycles, then move to OUT_LSB.
REQ-016 In CALC, the counter SHALL count 0..WIDTH-1; at the terminal count the state SHALL advance.
REQ-017 OUT_LSB SHALL assert data_oe and lsb_out for one cycle, then move to OUT_MSB.
REQ-018 OUT_MSB SHALL assert data_oe, msb_out and done for one cycle, then move to IDLE.
REQ-019 Timing SHALL be: start in cycle 0; lsb_out visible in cycle WIDTH+2; msb_out/done in cycle WIDTH+3; a new start is accepted from cycle WIDTH+4.
REQ-020 The product SHALL be exact at 2*WIDTH bits; no overflow is possible and none is flagged.
REQ-021 start while busy=1 SHALL be ignored and SHALL have no effect on the operation in progress.
REQ-022 start asserted in the same cycle the block returns to IDLE SHALL be ignored; it is accepted only when the state is IDLE at the sampling edge.
REQ-023 A zero operand SHALL still take the full WIDTH CALC cycles; there is no early termination.
REQ-024 lsb_out, msb_out and done SHALL never be high in the same cycle as each other, except done with msb_out.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter IDLE, and data_out, data_oe, lsb_out, msb_out, done and busy SHALL all be 0 in the next cycle.
REQ-026 rst in any state, including mid-CALC or OUT_LSB, SHALL abort the operation with no output phase.
REQ-027 rst SHALL have priority over start in the same cycle.

Configuration
REQ-028 Macro BUS_MULT_SIGNED_EN defined: operands and result SHALL be two's complement.
REQ-029 In signed mode, CALC SHALL multiply the magnitudes and negate the result when the operand signs differ; latency is unchanged.
REQ-030 Macro undefined: operands and result SHALL be unsigned, and no sign logic SHALL be synthesised.

Structure
REQ-031 Package bus_mult_pkg SHALL hold the state enum typedef and the WIDTH range bounds.
REQ-032 Sub-module mult_shift_add_core SHALL hold the accumulator, multiplier shift register and counter; the FSM and bus phasing SHALL stay in bus_mult_seq.

Verification (WIDTH=8 unless stated)
REQ-033 5 then 3 -> lsb 0x0F at cycle 10, msb 0x00 with done at cycle 11.
REQ-034 0xFF then 0xFF, unsigned -> lsb 0x01, msb 0xFE; signed (-1 x -1) -> lsb 0x01, msb 0x00.
REQ-035 Signed: 0xFF then 0x02 -> 0xFFFE; 0x80 then 0x80 -> 0x4000.
REQ-036 start pulsed in cycles 4 and 11 of a 7x9 operation -> one result only, 0x003F; start at cycle 12 is accepted.
REQ-037 rst at cycle 5 of CALC -> no lsb_out/msb_out/done; all outputs 0 next cycle; next 2x2 gives 0x0004.
REQ-038 WIDTH=16: 0xFFFF then 0x0002 -> lsb 0xFFFE, msb 0x0001 at cycles 18 and 19.
